// File: rtl/spi_xfer_engine.sv
// rtl/spi_xfer_engine.sv - SPI mode-0 master that exchanges bytes in place in the shared SPI buffer (port B).
// Optional build macro SPI_XFER_LOOPBACK_EN: sample the engine's own mosi instead of the miso pin.
module spi_xfer_engine #(
  parameter int addr_bits = 13,
  parameter int clk_div   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addr_bits:0]   xfer_len,
  output logic                 busy,
  output logic                 done,
  output logic [addr_bits-1:0] buf_addr,
  output logic [7:0]           buf_wr_val,
  output logic                 buf_wr_en,
  input  logic [7:0]           buf_rd_val,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 cs_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_FINISH
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(clk_div - 1);
  localparam logic [7:0] HOLD_LAST = 8'(clk_div);

  state_t               state_q, state_d;
  logic [addr_bits:0]   len_q, len_d;
  logic [addr_bits-1:0] index_q, index_d;
  logic [addr_bits:0]   index_inc;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [addr_bits-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]           buf_wr_val_q, buf_wr_val_d;
  logic                 buf_wr_en_q, buf_wr_en_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           half_q, half_d;
  logic [7:0]           hold_q, hold_d;
  logic                 sample_bit;

`ifdef SPI_XFER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample_bit  = mosi_q;
`else
  assign sample_bit  = miso;
`endif

  assign index_inc = {1'b0, index_q} + {{addr_bits{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    index_d      = index_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_wr_val_d = buf_wr_val_q;
    buf_wr_en_d  = 1'b0;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_d        = bit_q;
    half_d       = half_q;
    hold_d       = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (xfer_len != '0) begin
            len_d      = xfer_len;
            index_d    = '0;
            buf_addr_d = '0;
            cs_n_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // buf_addr already holds index; the buffer registers it at the end of FETCH.
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD: begin
        tx_d    = buf_rd_val;
        mosi_d  = buf_rd_val[7];
        sclk_d  = 1'b0;
        bit_d   = 3'd0;
        half_d  = 8'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], sample_bit};
          end else begin
            sclk_d = 1'b0;
            // The last falling edge leaves mosi on bit 0 and queues the write-back.
            if (bit_q == 3'd7) begin
              buf_addr_d   = index_q;
              buf_wr_val_d = rx_q;
              buf_wr_en_d  = 1'b1;
              state_d      = S_STORE;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
              bit_d  = bit_q + 3'd1;
            end
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      S_STORE: begin
        if (index_inc == len_q) begin
          hold_d  = 8'd0;
          state_d = S_FINISH;
        end else begin
          index_d    = index_inc[addr_bits-1:0];
          buf_addr_d = index_inc[addr_bits-1:0];
          state_d    = S_FETCH;
        end
      end
      // One cycle retires the write-back, then cs_n is held low for clk_div cycles.
      S_FINISH: begin
        if (hold_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      index_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      buf_addr_q   <= '0;
      buf_wr_val_q <= 8'd0;
      buf_wr_en_q  <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_q         <= 8'd0;
      rx_q         <= 8'd0;
      bit_q        <= 3'd0;
      half_q       <= 8'd0;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      buf_addr_q   <= buf_addr_d;
      buf_wr_val_q <= buf_wr_val_d;
      buf_wr_en_q  <= buf_wr_en_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_q        <= bit_d;
      half_q       <= half_d;
      hold_q       <= hold_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign buf_addr   = buf_addr_q;
  assign buf_wr_val = buf_wr_val_q;
  assign buf_wr_en  = buf_wr_en_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;

endmodule
